div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_pkg.sv | 19 +
 rtl/div_sign_fix.sv | 53 +++++
 rtl/div_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_pkg : shared FSM state type and constants for the divider.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package div_pkg;

  localparam int   WIDTH_DEFAULT     = 32;
  // The quotient reported for a zero divisor is this bit replicated across the word.
  localparam logic DIV_ZERO_QUOT_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/div_sign_fix.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_sign_fix : operand magnitudes on entry, result sign fix on exit. |
// | Signed support only when DIV_UNIT_SIGNED_EN is defined.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_sign_fix
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [WIDTH-1:0] abs1_o,
  output logic [WIDTH-1:0] abs2_o,
  output logic             neg_quot_o,
  output logic             neg_rem_o,
  input  logic [WIDTH-1:0] raw_quot_i,
  input  logic [WIDTH-1:0] raw_rem_i,
  input  logic             neg_quot_i,
  input  logic             neg_rem_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

`ifdef DIV_UNIT_SIGNED_EN
  logic s1_neg;
  logic s2_neg;

  assign s1_neg     = signed_i & src1_i[WIDTH-1];
  assign s2_neg     = signed_i & src2_i[WIDTH-1];
  assign abs1_o     = s1_neg ? (~src1_i + 1'b1) : src1_i;
  assign abs2_o     = s2_neg ? (~src2_i + 1'b1) : src2_i;
  // Truncating division: quotient sign from sign mismatch, remainder follows dividend.
  assign neg_quot_o = s1_neg ^ s2_neg;
  assign neg_rem_o  = s1_neg;
  assign quot_o     = neg_quot_i ? (~raw_quot_i + 1'b1) : raw_quot_i;
  assign rem_o      = neg_rem_i ? (~raw_rem_i + 1'b1) : raw_rem_i;
`else
  logic unused_sign;

  assign unused_sign = ^{signed_i, neg_quot_i, neg_rem_i};
  assign abs1_o      = src1_i;
  assign abs2_o      = src2_i;
  assign neg_quot_o  = 1'b0;
  assign neg_rem_o   = 1'b0;
  assign quot_o      = raw_quot_i;
  assign rem_o       = raw_rem_i;
`endif

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_unit : iterative restoring divider, one quotient bit per cycle.  |
// | Define DIV_UNIT_SIGNED_EN to enable signed (truncating) division.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             div_zero_o
);

  localparam int             CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_acc_q, rem_acc_d;
  logic [WIDTH-1:0]   quo_acc_q, quo_acc_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   abs1, abs2;
  logic               ent_neg_quot, ent_neg_rem;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_step, quo_step;
  logic [WIDTH-1:0]   fix_quot, fix_rem;

  div_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .signed_i   (signed_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .abs1_o     (abs1),
    .abs2_o     (abs2),
    .neg_quot_o (ent_neg_quot),
    .neg_rem_o  (ent_neg_rem),
    .raw_quot_i (quo_step),
    .raw_rem_i  (rem_step),
    .neg_quot_i (neg_quot_q),
    .neg_rem_i  (neg_rem_q),
    .quot_o     (fix_quot),
    .rem_o      (fix_rem)
  );

  // A borrow out of the (WIDTH+1)-bit trial subtraction means the divisor did not fit.
  always_comb begin
    trial = {rem_acc_q, quo_acc_q[WIDTH-1]} - {1'b0, divisor_q};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo_acc_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = {rem_acc_q[WIDTH-2:0], quo_acc_q[WIDTH-1]};
      quo_step = {quo_acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_acc_d  = rem_acc_q;
    quo_acc_d  = quo_acc_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          div_zero_d = 1'b0;
          neg_quot_d = ent_neg_quot;
          neg_rem_d  = ent_neg_rem;
          if (src2_i == '0) begin
            state_d    = DONE;
            div_zero_d = 1'b1;
            quot_d     = {WIDTH{DIV_ZERO_QUOT_BIT}};
            rem_d      = src1_i;
          end else begin
            state_d   = CALC;
            cnt_d     = '0;
            rem_acc_d = '0;
            quo_acc_d = abs1;
            divisor_d = abs2;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_acc_d = rem_step;
        quo_acc_d = quo_step;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          quot_d  = fix_quot;
          rem_d   = fix_rem;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_acc_q  <= '0;
      quo_acc_q  <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_acc_q  <= rem_acc_d;
      quo_acc_q  <= quo_acc_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy_o     = (state_q == CALC);
  assign done_o     = (state_q == DONE);
  assign quot_o     = quot_q;
  assign rem_o      = rem_q;
  assign div_zero_o = div_zero_q;

endmodule
`default_nettype wire
